// File: rtl/adder_pkg.sv
// Shared definitions for the segmented adder sequencer.
// Contents:
//   state_e       FSM state encoding (IDLE, RUN, DONE)
//   counterWidth  width of the slice index counter, clog2 with a floor of 1
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-slice configuration still needs a one-bit index register,
    // so the width never drops below 1.
    function automatic int counterWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Ports:
//   a, b, cin  operand bits and carry-in
//   s, cout    sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Standard sum/majority equations.
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seg_ripple_add.sv
// Combinational SEG-bit ripple-carry adder built by chaining full_adder cells.
// Ports:
//   a, b   SEG-bit operands
//   cin    carry into bit 0
//   s      SEG-bit sum
//   cout   carry out of the top bit
module seg_ripple_add #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic [SEG:0] carryChain;

    // Carry ripples from bit 0 upwards; the top of the chain is the slice carry-out.
    assign carryChain[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : gBit
        full_adder uFa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carryChain[i]),
            .s    (s[i]),
            .cout (carryChain[i+1])
        );
    end

    assign cout = carryChain[SEG];

endmodule

// File: rtl/segmented_add_sequencer.sv
// Multi-cycle wide adder/subtractor. Operands are taken over a valid/ready
// handshake and summed LSB-first one SEG-bit slice per clock through a single
// seg_ripple_add, with the inter-slice carry held in a flop. The result is held
// until the consumer accepts it.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand request handshake
//   in_a, in_b            W-bit operands
//   in_cin                carry-in (ignored when subtracting)
//   in_sub                1 = compute A - B
//   out_valid / out_ready result handshake
//   out_sum               W-bit sum/difference
//   out_cout              carry out of the MSB (for subtract: 1 = no borrow)
//   out_ovf               two's-complement signed overflow
//   busy                  block is not idle
module segmented_add_sequencer
    import adder_pkg::*;
#(
    parameter int W   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         busy
);

    localparam int NSEG = W / SEG;
    localparam int CW   = counterWidth(NSEG);
    localparam logic [CW-1:0] LAST_IDX = CW'(NSEG - 1);

    // The slicing only makes sense when the operand splits into whole slices.
    if ((W % SEG) != 0 || NSEG < 1) begin : gBadParams
        $error("segmented_add_sequencer: W must be a non-zero multiple of SEG");
    end

    state_e        state_q;
    logic [CW-1:0] idx_q;
    logic [W-1:0]  opA_q;
    logic [W-1:0]  opBEff_q;
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          inReady_q;
    logic          outValid_q;
    logic          busy_q;

    logic [SEG-1:0] sliceA;
    logic [SEG-1:0] sliceB;
    logic [SEG-1:0] sliceSum;
    logic           sliceCout;

    // Pick the operand slice addressed by the running index; B is already
    // stored inverted for subtraction, so the slice adder never needs to know.
    always_comb begin
        sliceA = opA_q[int'(idx_q) * SEG +: SEG];
        sliceB = opBEff_q[int'(idx_q) * SEG +: SEG];
    end

    seg_ripple_add #(
        .SEG (SEG)
    ) uSliceAdd (
        .a    (sliceA),
        .b    (sliceB),
        .cin  (carry_q),
        .s    (sliceSum),
        .cout (sliceCout)
    );

    // Single FSM block: IDLE latches a request, RUN walks the slices writing
    // each partial sum in place and carrying into the next, DONE holds the
    // result until the consumer takes it. Handshake outputs are registered
    // alongside the state so they always match it. A reset discards any
    // operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            opA_q      <= '0;
            opBEff_q   <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opA_q     <= in_a;
                        opBEff_q  <= in_b ^ {W{in_sub}};
                        carry_q   <= in_sub ? 1'b1 : in_cin;
                        idx_q     <= '0;
                        sum_q     <= '0;
                        state_q   <= RUN;
                        inReady_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q) * SEG +: SEG] <= sliceSum;
                    carry_q <= sliceCout;
                    if (idx_q == LAST_IDX) begin
                        state_q    <= DONE;
                        outValid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign busy      = busy_q;
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

    // Signed overflow: both effective operands share a sign the result does not.
    assign out_ovf = (opA_q[W-1] == opBEff_q[W-1]) & (sum_q[W-1] != opA_q[W-1]);

endmodule

// File: tb/tb_segmented_add_sequencer.sv
// Self-checking bench for segmented_add_sequencer: a table of hand-computed
// add/subtract vectors on a W=32/SEG=8 instance, plus directed sequences for
// backpressure, mid-operation reset and a single-slice W=8/SEG=8 instance.
module tb_segmented_add_sequencer;

    logic        clk;
    logic        rst_n;

    logic        inValid;
    logic        inReady;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        inCin;
    logic        inSub;
    logic        outValid;
    logic        outReady;
    logic [31:0] outSum;
    logic        outCout;
    logic        outOvf;
    logic        busy;

    logic        inValid8;
    logic        inReady8;
    logic [7:0]  inA8;
    logic [7:0]  inB8;
    logic        inCin8;
    logic        inSub8;
    logic        outValid8;
    logic        outReady8;
    logic [7:0]  outSum8;
    logic        outCout8;
    logic        outOvf8;
    logic        busy8;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] expSum;
        logic        expCout;
        logic        expOvf;
    } vector_t;

    vector_t vectors[11];

    segmented_add_sequencer #(.W(32), .SEG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_a      (inA),
        .in_b      (inB),
        .in_cin    (inCin),
        .in_sub    (inSub),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_sum   (outSum),
        .out_cout  (outCout),
        .out_ovf   (outOvf),
        .busy      (busy)
    );

    segmented_add_sequencer #(.W(8), .SEG(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid8),
        .in_ready  (inReady8),
        .in_a      (inA8),
        .in_b      (inB8),
        .in_cin    (inCin8),
        .in_sub    (inSub8),
        .out_valid (outValid8),
        .out_ready (outReady8),
        .out_sum   (outSum8),
        .out_cout  (outCout8),
        .out_ovf   (outOvf8),
        .busy      (busy8)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present one request at a negedge and hold it through the accept edge,
    // then scramble the inputs to show the block does not depend on them.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        @(negedge clk);
        checkOutput("in_ready before accept", 32'(inReady), 32'd1);
        inA     = a;
        inB     = b;
        inCin   = cin;
        inSub   = sub;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inA     = $urandom;
        inB     = $urandom;
        inCin   = 1'($urandom);
        inSub   = 1'($urandom);
    endtask

    // Count edges after the accept edge until out_valid shows up, bounded.
    task automatic waitDone(input string name, input int expLat);
        int  lat  = 0;
        bit  seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            seen = outValid;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
    endtask

    task automatic checkResult(input string name, input logic [31:0] s, input logic c, input logic o);
        checkOutput({name, " sum"}, outSum, s);
        checkOutput({name, " cout/ovf"}, {30'd0, outCout, outOvf}, {30'd0, c, o});
        checkOutput({name, " in_ready/busy in DONE"}, {30'd0, inReady, busy}, {30'd0, 1'b0, 1'b1});
    endtask

    // Accept the result for one edge and confirm the block is back in IDLE.
    task automatic releaseResult(input string name);
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput({name, " idle after accept"}, {29'd0, outValid, inReady, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        logic [31:0] heldSum;
        logic [1:0]  heldFlags;

        vectors[0]  = '{"ones_plus_one",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vectors[1]  = '{"sub_5_7",        32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vectors[2]  = '{"pos_ovf",        32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vectors[3]  = '{"neg_ovf_sub",    32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vectors[4]  = '{"small_add",      32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0};
        vectors[5]  = '{"add_with_cin",   32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
        vectors[6]  = '{"min_plus_min",   32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vectors[7]  = '{"sub_equal",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vectors[8]  = '{"zero_minus_one", 32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vectors[9]  = '{"slice_carry",    32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0};
        vectors[10] = '{"cin_ripple",     32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0, 32'h0001FFFF, 1'b0, 1'b0};

        rst_n     = 1'b0;
        inValid   = 1'b0;
        inA       = '0;
        inB       = '0;
        inCin     = 1'b0;
        inSub     = 1'b0;
        outReady  = 1'b0;
        inValid8  = 1'b0;
        inA8      = '0;
        inB8      = '0;
        inCin8    = 1'b0;
        inSub8    = 1'b0;
        outReady8 = 1'b0;

        #12;
        checkOutput("reset sum", outSum, 32'h0);
        checkOutput("reset flags", {28'd0, outCout, outOvf, outValid, busy}, 32'h0);
        checkOutput("reset in_ready", 32'(inReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors, each with the full handshake and 4-cycle latency.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].cin, vectors[i].sub);
            waitDone(vectors[i].name, 4);
            checkResult(vectors[i].name, vectors[i].expSum, vectors[i].expCout, vectors[i].expOvf);
            releaseResult(vectors[i].name);
        end

        // Backpressure: the result must sit still while the consumer stalls.
        applyStimulus(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0);
        waitDone("backpressure", 4);
        checkResult("backpressure", 32'h10101010, 1'b0, 1'b0);
        heldSum   = outSum;
        heldFlags = {outCout, outOvf};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput("backpressure hold", {outSum[29:0], outCout, outOvf},
                        {heldSum[29:0], heldFlags});
            checkOutput("backpressure handshake", {30'd0, outValid, inReady}, {30'd0, 1'b1, 1'b0});
        end
        releaseResult("backpressure");
        applyStimulus(32'h00000010, 32'h00000020, 1'b0, 1'b0);
        waitDone("back_to_back_1", 4);
        checkResult("back_to_back_1", 32'h00000030, 1'b0, 1'b0);
        releaseResult("back_to_back_1");
        applyStimulus(32'h00000100, 32'h00000001, 1'b0, 1'b1);
        waitDone("back_to_back_2", 4);
        checkResult("back_to_back_2", 32'h000000FF, 1'b1, 1'b0);
        releaseResult("back_to_back_2");

        // Reset in the middle of RUN clears everything without a clock edge.
        applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun reset sum", outSum, 32'h0);
        checkOutput("midrun reset flags", {28'd0, outCout, outOvf, outValid, busy}, 32'h0);
        checkOutput("midrun reset in_ready", 32'(inReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h00000003, 32'h00000004, 1'b0, 1'b0);
        waitDone("after_reset", 4);
        checkResult("after_reset", 32'h00000007, 1'b0, 1'b0);
        releaseResult("after_reset");

        // Single-slice instance: one RUN cycle.
        @(negedge clk);
        inA8     = 8'h80;
        inB8     = 8'h80;
        inCin8   = 1'b0;
        inSub8   = 1'b0;
        inValid8 = 1'b1;
        @(posedge clk);
        #1;
        inValid8 = 1'b0;
        inA8     = 8'h5A;
        inB8     = 8'hA5;
        checkOutput("w8 not valid during run", {30'd0, outValid8, busy8}, {30'd0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        checkOutput("w8 valid after 1 cycle", 32'(outValid8), 32'd1);
        checkOutput("w8 sum", 32'(outSum8), 32'h00);
        checkOutput("w8 cout/ovf", {30'd0, outCout8, outOvf8}, {30'd0, 1'b1, 1'b1});
        @(negedge clk);
        outReady8 = 1'b1;
        @(posedge clk);
        #1;
        outReady8 = 1'b0;
        checkOutput("w8 idle after accept", {30'd0, outValid8, inReady8}, {30'd0, 1'b0, 1'b1});

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
